// File: rtl/rv32i_pkg.sv
// Shared RV32I constants used by the fetch front end.
package rv32i_pkg;
  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h00000013;
  localparam int          PC_STEP  = 4;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read and a synchronous clear.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: runs the PC ahead of decode and buffers
// returned words with their PCs; a redirect flushes everything in one cycle.
module fetch_queue
  import rv32i_pkg::*;
#(
  parameter int               XLEN     = rv32i_pkg::XLEN,
  parameter int               ADDR_W   = 16,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     im_en,
  output logic [ADDR_W-1:0]        im_addr,
  input  logic [31:0]              im_rdata,
  input  logic                     flush,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     d_valid,
  output logic [31:0]              d_inst,
  output logic [XLEN-1:0]          d_pc,
  input  logic                     d_ready,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
  logic               inflight_q, inflight_d;
  logic [XLEN-1:0]    inflight_pc_q, inflight_pc_d;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty, fifo_full;
  logic [31+XLEN:0]   fifo_rdata;
  logic [CNT_W:0]     occupancy;
  logic               issue, push, pop;

  // Count the outstanding read so a full FIFO always has room for it.
  assign occupancy = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q);
  assign issue     = !rst && !flush && !fifo_full && (occupancy < (CNT_W+1)'(DEPTH));
  assign push      = inflight_q && !flush;
  assign pop       = d_valid && d_ready && !flush;

  assign im_en   = issue;
  assign im_addr = fetch_pc_q[ADDR_W-1:0];
  assign d_valid = !fifo_empty;
  assign d_inst  = fifo_empty ? NOP_INST : fifo_rdata[31+XLEN:XLEN];
  assign d_pc    = fifo_empty ? '0 : fifo_rdata[XLEN-1:0];
  assign count   = fifo_count;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (flush) begin
      fetch_pc_d = redirect_pc & ~XLEN'(3);
    end else if (issue) begin
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + XLEN'(PC_STEP);
      inflight_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  sync_fifo #(
    .WIDTH (32 + XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (flush),
    .wdata ({im_rdata, inflight_pc_q}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed phases push expected {inst,pc}
// entries; monitors pop and compare every accepted decode handshake.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst, flush, d_ready;
  logic [31:0] redirect_pc;

  logic        im_en, d_valid;
  logic [15:0] im_addr;
  logic [31:0] im_rdata, d_inst, d_pc;
  logic [2:0]  count;

  logic        w_im_en, w_d_valid;
  logic [15:0] w_im_addr;
  logic [31:0] w_im_rdata, w_d_inst, w_d_pc;
  logic [2:0]  w_count;

  int checks = 0;
  int errors = 0;
  logic w_en;
  logic [63:0] exp_q[$];
  logic [63:0] exp_w[$];

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(32), .ADDR_W(16), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst), .im_en(im_en), .im_addr(im_addr), .im_rdata(im_rdata),
    .flush(flush), .redirect_pc(redirect_pc), .d_valid(d_valid), .d_inst(d_inst),
    .d_pc(d_pc), .d_ready(d_ready), .count(count));

  fetch_queue #(.XLEN(32), .ADDR_W(16), .DEPTH(4), .RESET_PC(32'hFFFFFFF8)) u_dut_w (
    .clk(clk), .rst(rst), .im_en(w_im_en), .im_addr(w_im_addr), .im_rdata(w_im_rdata),
    .flush(flush), .redirect_pc(redirect_pc), .d_valid(w_d_valid), .d_inst(w_d_inst),
    .d_pc(w_d_pc), .d_ready(d_ready), .count(w_count));

  // Memory model: the word at address N is N, returned one cycle after the request.
  always @(posedge clk) begin
    if (im_en)   im_rdata   <= {16'h0, im_addr};
    if (w_im_en) w_im_rdata <= {16'h0, w_im_addr};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ent(input logic [31:0] pc);
    return {16'h0, pc[15:0], pc};
  endfunction

  always @(negedge clk) begin
    if (!rst && !flush && d_ready && d_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deliver_unexpected got pc %h inst %h expected none", d_pc, d_inst);
      end else begin
        chk("deliver", {d_inst, d_pc}, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (w_en && !rst && !flush && d_ready && w_d_valid) begin
      if (exp_w.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wrap_deliver_unexpected got pc %h expected none", w_d_pc);
      end else begin
        chk("wrap_deliver", {w_d_inst, w_d_pc}, exp_w.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; d_ready = 1'b0; redirect_pc = '0; w_en = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_im_en", im_en, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_d_inst", d_inst, 32'h13);
    chk("rst_d_pc", d_pc, 0);
    chk("rst_count", count, 0);

    // Streaming with d_ready=1, both the zero and the wrapping reset PC.
    exp_q.push_back(ent(32'h0));  exp_q.push_back(ent(32'h4));
    exp_q.push_back(ent(32'h8));  exp_q.push_back(ent(32'hC));
    exp_w.push_back(ent(32'hFFFFFFF8)); exp_w.push_back(ent(32'hFFFFFFFC));
    exp_w.push_back(ent(32'h0));        exp_w.push_back(ent(32'h4));
    tick(); rst = 1'b0; d_ready = 1'b1;
    @(negedge clk);
    chk("c0_im_en", im_en, 1);
    chk("c0_im_addr", im_addr, 16'h0);
    chk("c0_d_valid", d_valid, 0);
    chk("c0_w_im_addr", w_im_addr, 16'hFFF8);
    tick(); @(negedge clk);
    chk("c1_d_valid", d_valid, 0);
    chk("c1_im_addr", im_addr, 16'h4);
    tick(); @(negedge clk);
    chk("c2_d_valid", d_valid, 1);
    chk("c2_d_pc", d_pc, 0);
    chk("c2_w_d_pc", w_d_pc, 32'hFFFFFFF8);
    repeat (4) tick();
    rst = 1'b1; d_ready = 1'b0;
    @(negedge clk);
    chk("rst_mid_im_en", im_en, 0);
    tick(); w_en = 1'b0;
    @(negedge clk);
    chk("rst_mid_d_valid", d_valid, 0);
    chk("rst_mid_d_inst", d_inst, 32'h13);
    chk("rst_mid_d_pc", d_pc, 0);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_w_d_valid", w_d_valid, 0);
    chk("rst_mid_w_d_pc", w_d_pc, 0);
    chk("rst_mid_w_count", w_count, 0);
    chk("wrap_drained", exp_w.size(), 0);

    // Fill with d_ready=0, then single pops and a push/pop at count 3.
    tick(); rst = 1'b0; d_ready = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    chk("fill_count", count, 4);
    chk("fill_im_en", im_en, 0);
    tick(); @(negedge clk);
    chk("fill_hold_im_en", im_en, 0);
    tick(); d_ready = 1'b1; exp_q.push_back(ent(32'h0));
    @(negedge clk);
    chk("pop_cycle_im_en", im_en, 0);
    tick(); d_ready = 1'b0;
    @(negedge clk);
    chk("after_pop_count", count, 3);
    chk("after_pop_im_en", im_en, 1);
    chk("after_pop_im_addr", im_addr, 16'h10);
    tick(); d_ready = 1'b1; exp_q.push_back(ent(32'h4));
    @(negedge clk);
    chk("one_issue_im_en", im_en, 0);
    chk("pushpop_pre_count", count, 3);
    tick(); d_ready = 1'b0;
    @(negedge clk);
    chk("pushpop_count", count, 3);
    chk("reissue_im_addr", im_addr, 16'h14);
    tick(); @(negedge clk);
    chk("reissue_hold_im_en", im_en, 0);
    tick(); d_ready = 1'b1; exp_q.push_back(ent(32'h8));
    @(negedge clk);
    chk("refill_count", count, 4);
    tick(); d_ready = 1'b0;
    @(negedge clk);
    chk("pre_flush_im_addr", im_addr, 16'h18);

    // Flush at count=3 with a read in flight and d_ready=1.
    tick(); flush = 1'b1; redirect_pc = 32'h100; d_ready = 1'b1;
    exp_q.push_back(ent(32'h100)); exp_q.push_back(ent(32'h104));
    exp_q.push_back(ent(32'h108));
    @(negedge clk);
    chk("flush_pre_count", count, 3);
    chk("flush_im_en", im_en, 0);
    tick(); flush = 1'b0;
    @(negedge clk);
    chk("post_flush_count", count, 0);
    chk("post_flush_d_valid", d_valid, 0);
    chk("post_flush_d_inst", d_inst, 32'h13);
    chk("post_flush_im_en", im_en, 1);
    chk("post_flush_im_addr", im_addr, 16'h100);
    tick(); @(negedge clk);
    chk("flush_f2_d_valid", d_valid, 0);
    tick(); @(negedge clk);
    chk("flush_f3_d_valid", d_valid, 1);
    chk("flush_f3_d_pc", d_pc, 32'h100);
    tick(); tick();

    // Misaligned redirect target is rounded down to a word.
    tick(); flush = 1'b1; redirect_pc = 32'h203; d_ready = 1'b0;
    tick(); flush = 1'b0;
    @(negedge clk);
    chk("misalign_im_addr", im_addr, 16'h200);
    chk("misalign_count", count, 0);
    chk("main_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
